// File: rtl/imem_sync_port.sv
// Synchronous word-organised instruction memory with a valid/ready fetch port,
// configurable wait states, fault detection and a run-time program-load port.
module imem_sync_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_WORD = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic                  rsp_fault,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-3:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic [3:0] r_cnt;
  logic [3:0] w_next_cnt;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: INIT_WORD};
  logic [DATA_WIDTH-1:0] r_rsp_instr;
  logic                  r_rsp_fault;

  logic [IDX_W-1:0]  w_idx;
  logic [MEM_AW-1:0] w_mem_idx;
  logic              w_fault;
  logic              w_accept;
  logic              w_req_ready;
  logic              w_load_ok;

  assign w_idx     = req_addr[ADDR_WIDTH-1:2];
  assign w_mem_idx = w_idx[MEM_AW-1:0];
  assign w_fault   = (req_addr[1:0] != 2'b00) || ({1'b0, w_idx} >= DEPTH_L);
  assign w_load_ok = ({1'b0, load_addr} < DEPTH_L);

  // A load in flight blocks new fetches so a fetch never races its own program write.
  assign w_req_ready = !rst && !load_en &&
                       ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready));
  assign w_accept    = req_valid && w_req_ready;

  assign req_ready = w_req_ready;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_instr = r_rsp_instr;
  assign rsp_fault = r_rsp_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          w_next_state = NO_WAIT ? S_RESP : S_WAIT;
          w_next_cnt   = WS_LOAD;
        end else if ((r_state == S_RESP) && rsp_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = r_state;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = S_RESP;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // Response is snapshotted at accept so later loads cannot change a pending fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_instr <= '0;
      r_rsp_fault <= 1'b0;
    end else if (w_accept) begin
      r_rsp_instr <= w_fault ? '0 : r_mem[w_mem_idx];
      r_rsp_fault <= w_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && w_load_ok) begin
      r_mem[load_addr[MEM_AW-1:0]] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_sync_port.sv
// Self-checking bench for imem_sync_port: a zero-wait and a three-wait-state
// instance checked every cycle against a transaction-level model plus literals.
module tb_imem_sync_port;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  load_en;
  logic [31:0] req_addr  [2];
  logic [29:0] load_addr [2];
  logic [31:0] load_data [2];
  wire  [1:0]  req_ready_w;
  wire  [1:0]  rsp_valid_w;
  wire  [1:0]  rsp_fault_w;
  wire  [63:0] rsp_instr_w;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit meas_en = 1'b0;
  int cyc = 0;
  int first_rsp = -1;
  int acc_q[$];

  // Model state: per-instance memory image and at most one outstanding response.
  logic [31:0] m_mem [2][1024];
  bit          m_pend [2];
  int          m_wait [2];
  logic [31:0] m_instr [2];
  bit          m_fault [2];
  bit          m_acc, m_take, m_f;
  int          m_idx;

  always #5 clk = ~clk;

  imem_sync_port #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready_w[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready[0]), .rsp_instr(rsp_instr_w[31:0]),
    .rsp_fault(rsp_fault_w[0]),
    .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0])
  );

  imem_sync_port #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready_w[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready[1]), .rsp_instr(rsp_instr_w[63:32]),
    .rsp_fault(rsp_fault_w[1]),
    .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1])
  );

  function automatic int ws(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] dut_instr(input int i);
    return (i == 0) ? rsp_instr_w[31:0] : rsp_instr_w[63:32];
  endfunction

  function automatic logic exp_valid(input int i);
    return m_pend[i] && (m_wait[i] == 0);
  endfunction

  function automatic logic exp_ready(input int i);
    return !rst && !load_en[i] && (!m_pend[i] || (exp_valid(i) && rsp_ready[i]));
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model update: accept snapshots data, wait count drains, consumer takes response.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = 1'b0;
        m_wait[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_acc  = req_valid[i] && exp_ready(i);
        m_take = exp_valid(i) && rsp_ready[i];
        if (m_pend[i] && m_wait[i] > 0) m_wait[i] = m_wait[i] - 1;
        if (m_take) m_pend[i] = 1'b0;
        if (m_acc) begin
          m_idx = int'(req_addr[i] >> 2);
          m_f   = (req_addr[i][1:0] != 2'b00) || (m_idx >= 1024);
          m_instr[i] = m_f ? 32'h0 : m_mem[i][m_idx];
          m_fault[i] = m_f;
          m_pend[i]  = 1'b1;
          m_wait[i]  = ws(i);
        end
        if (load_en[i] && load_addr[i] < 30'd1024) m_mem[i][load_addr[i][9:0]] = load_data[i];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("req_ready[%0d]", i), {63'd0, req_ready_w[i]}, {63'd0, exp_ready(i)});
        check($sformatf("rsp_valid[%0d]", i), {63'd0, rsp_valid_w[i]}, {63'd0, exp_valid(i)});
        if (rst) begin
          check($sformatf("rst_instr[%0d]", i), {32'd0, dut_instr(i)}, 64'd0);
          check($sformatf("rst_fault[%0d]", i), {63'd0, rsp_fault_w[i]}, 64'd0);
        end else if (exp_valid(i)) begin
          check($sformatf("rsp_instr[%0d]", i), {32'd0, dut_instr(i)}, {32'd0, m_instr[i]});
          check($sformatf("rsp_fault[%0d]", i), {63'd0, rsp_fault_w[i]}, {63'd0, m_fault[i]});
        end
      end
    end
  end

  // Handshake timing of the three-wait instance, in clock-edge numbers.
  always @(negedge clk) begin
    if (meas_en) begin
      if (req_valid[1] && req_ready_w[1]) acc_q.push_back(cyc + 1);
      if (rsp_valid_w[1] && first_rsp < 0) first_rsp = cyc + 1;
    end
  end

  task automatic load_word(input int i, input logic [29:0] a, input logic [31:0] d);
    load_en[i] = 1'b1;
    load_addr[i] = a;
    load_data[i] = d;
    step();
    load_en[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, input logic [31:0] ei, input logic ef, input string nm);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (rsp_valid_w[i]) begin
        got = 1'b1;
        check({nm, "_instr"}, {32'd0, dut_instr(i)}, {32'd0, ei});
        check({nm, "_fault"}, {63'd0, rsp_fault_w[i]}, {63'd0, ef});
      end else begin
        step();
      end
    end
    if (!got) check({nm, "_rsp_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic fetch_and_expect(input int i, input logic [31:0] a, input logic [31:0] ei,
                                  input logic ef, input string nm);
    bit acc = 1'b0;
    rsp_ready[i] = 1'b1;
    req_valid[i] = 1'b1;
    req_addr[i]  = a;
    for (int n = 0; n < 20 && !acc; n++) begin
      acc = exp_ready(i);
      step();
    end
    req_valid[i] = 1'b0;
    if (!acc) check({nm, "_accept_timeout"}, 64'd0, 64'd1);
    wait_rsp(i, ei, ef, nm);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    load_en = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = 32'd0;
      load_addr[i] = 30'd0;
      load_data[i] = 32'd0;
      for (int w = 0; w < 1024; w++) m_mem[i][w] = 32'h00000013;
    end
    chk_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("reset_ready0", {63'd0, req_ready_w[0]}, 64'd1);
    check("reset_valid0", {63'd0, rsp_valid_w[0]}, 64'd0);

    load_word(0, 30'd0, 32'h00500093);
    load_word(0, 30'd1, 32'h00A00113);
    load_word(1, 30'd0, 32'h00500093);
    load_word(1, 30'd2, 32'h11111111);

    // Zero-wait fetch of 0x0; response visible right after the accept edge.
    req_valid[0] = 1'b1;
    req_addr[0] = 32'h0;
    step();
    req_valid[0] = 1'b0;
    #1;
    check("t1_valid", {63'd0, rsp_valid_w[0]}, 64'd1);
    check("t1_instr", {32'd0, rsp_instr_w[31:0]}, 64'h00500093);
    check("t1_fault", {63'd0, rsp_fault_w[0]}, 64'd0);

    // Backpressure holds the response and blocks new requests.
    for (int n = 0; n < 3; n++) begin
      step();
      check("t2_hold_instr", {32'd0, rsp_instr_w[31:0]}, 64'h00500093);
      check("t2_hold_ready", {63'd0, req_ready_w[0]}, 64'd0);
    end
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_addr[0] = 32'h4;
    #1;
    check("t2_b2b_ready", {63'd0, req_ready_w[0]}, 64'd1);
    step();
    req_valid[0] = 1'b0;
    #1;
    check("t2_b2b_valid", {63'd0, rsp_valid_w[0]}, 64'd1);
    check("t2_b2b_instr", {32'd0, rsp_instr_w[31:0]}, 64'h00A00113);
    step();

    fetch_and_expect(0, 32'h6, 32'h0, 1'b1, "t3_misaligned");
    fetch_and_expect(0, 32'h1000, 32'h0, 1'b1, "t3_out_of_range");
    fetch_and_expect(0, 32'hFFC, 32'h00000013, 1'b0, "t3_last_word");

    // Three wait states: continuous requests, measure latency and spacing.
    meas_en = 1'b1;
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b1;
    req_addr[1] = 32'h0;
    repeat (14) step();
    req_valid[1] = 1'b0;
    meas_en = 1'b0;
    repeat (6) step();
    if (acc_q.size() >= 3) begin
      check("t4_latency", 64'(first_rsp - acc_q[0]), 64'd4);
      check("t4_spacing1", 64'(acc_q[1] - acc_q[0]), 64'd4);
      check("t4_spacing2", 64'(acc_q[2] - acc_q[1]), 64'd4);
    end else begin
      check("t4_accept_count", 64'(acc_q.size()), 64'd3);
    end

    // Load during WAIT must not disturb the pending response.
    req_valid[1] = 1'b1;
    req_addr[1] = 32'h8;
    step();
    req_valid[1] = 1'b0;
    load_en[1] = 1'b1;
    load_addr[1] = 30'd2;
    load_data[1] = 32'h22222222;
    #1;
    check("t5_ready_in_wait", {63'd0, req_ready_w[1]}, 64'd0);
    step();
    load_en[1] = 1'b0;
    wait_rsp(1, 32'h11111111, 1'b0, "t5_snapshot");
    step();
    fetch_and_expect(1, 32'h8, 32'h22222222, 1'b0, "t5_reloaded");

    // Held load blocks requests; its out-of-range index must not alias onto word 976.
    load_en[1] = 1'b1;
    load_addr[1] = 30'd2000;
    load_data[1] = 32'hDEADBEEF;
    req_valid[1] = 1'b1;
    req_addr[1] = 32'h0;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("t5_load_blocks", {63'd0, req_ready_w[1]}, 64'd0);
      step();
    end
    load_en[1] = 1'b0;
    req_valid[1] = 1'b0;
    fetch_and_expect(1, 32'hF40, 32'h00000013, 1'b0, "t5_oob_load_ignored");

    // Asynchronous reset in the middle of a wait.
    req_valid[1] = 1'b1;
    req_addr[1] = 32'h0;
    step();
    req_valid[1] = 1'b0;
    step();
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_valid", {63'd0, rsp_valid_w[1]}, 64'd0);
    check("t6_async_ready", {63'd0, req_ready_w[1]}, 64'd0);
    check("t6_async_instr", {32'd0, rsp_instr_w[63:32]}, 64'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("t6_ready_after", {63'd0, req_ready_w[1]}, 64'd1);
    check("t6_valid_after", {63'd0, rsp_valid_w[1]}, 64'd0);
    fetch_and_expect(1, 32'h0, 32'h00500093, 1'b0, "t6_mem_kept3");
    fetch_and_expect(0, 32'h0, 32'h00500093, 1'b0, "t6_mem_kept0");

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
